pc_seq_ras: RTL and testbench

Parametrised program-counter sequencer for the multicycle datapath; the successor to the single-mode PC incrementer.
- Updates PC once per instruction, in the control FSM's write-back state.
- Supports sequential, PC-relative branch, absolute jump (register target) and return modes.
- Return mode is served by an internal return-address stack (RAS).
- Sits between the control FSM/branch comparator and instruction memory addressing.

---
 rtl/pc_pkg.sv | 29 ++
 rtl/ras_stack.sv | 68 ++++++
 rtl/pc_seq_ras.sv | 157 +++++++++++++++
 tb/tb_pc_seq_ras.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Purpose : shared encodings, defaults and address helpers for the PC sequencer.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pc_pkg;

   // pc_src selector encodings.
   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,   // PC + INC
      PC_BR  = 2'b01,   // PC + word-converted signed byte offset
      PC_JMP = 2'b10,   // absolute word target
      PC_RET = 2'b11    // pop return-address stack
   } pc_src_e;

   // Control FSM state code in which the PC advances (write-back).
   localparam logic [3:0] UPDATE_STATE_DEFAULT = 4'b1000;

   // Working width for sign-extended offsets; wide enough for any PC_W we build.
   localparam int OFF_W = 64;

   // Convert a signed byte offset to a signed word offset. The arithmetic
   // shift floors negative offsets (-2 bytes -> -1 word with a shift of 2).
   function automatic logic signed [OFF_W-1:0] byte_to_word(
      input logic signed [OFF_W-1:0] byte_off,
      input int                      shift
   );
      return byte_off >>> shift;
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Purpose : circular LIFO of return addresses with count, full/empty flags,
//           push, pop, in-place replace and overwrite-oldest when full.
// Latency : top is combinational from storage; push/pop take effect next edge.
// Backpressure: none; a push on a full stack silently drops the oldest entry,
//           a pop on an empty stack is ignored (caller flags the underflow).
// Ports   : clk, rst_n      clock and async active-low reset
//           push, pop       operations for this edge (both = replace top)
//           push_data       value written on push / replace
//           top             current top-of-stack (undefined when empty)
//           empty, full     occupancy flags
module ras_stack #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr;       // next free slot; the top entry sits at ptr-1
   logic [PTR_W-1:0] top_idx;
   logic [CNT_W-1:0] count;
   logic             do_pop;

   assign top_idx = ptr - PTR_W'(1);
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign top     = mem[top_idx];

   // A pop on an empty stack has nothing to remove.
   assign do_pop  = pop && !empty;

   // Pointer and count. DEPTH is a power of two so the pointer wraps for
   // free; when full, the slot at ptr holds the oldest entry, so a plain push
   // overwrites it while the count saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
      end else if (do_pop && !push) begin
         ptr   <= top_idx;
         count <= count - CNT_W'(1);
      end else if (push && !do_pop) begin
         ptr <= ptr + PTR_W'(1);
         if (!full) begin
            count <= count + CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: contents are only read when count is non-zero.
   // Pop+push rewrites the current top in place.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[do_pop ? top_idx : ptr] <= push_data;
      end
   end

endmodule

// File: rtl/pc_seq_ras.sv
// Purpose : program-counter sequencer (sequential / relative branch / absolute
//           jump / return) with an internal return-address stack.
// Latency : PC changes on the edge where the update strobe is high; visible next cycle.
// Backpressure: stall (or any state other than UPDATE_STATE) freezes all state.
// Ports   : clk, rst_n              clock, async active-low reset
//           estado, stall           control FSM state and hold request
//           pc_src, imediato, target next-PC select, signed byte offset, word target
//           call                    push PC+INC on this update (ignored for sequential)
//           PC, pc_plus_inc         current PC and its combinational successor
//           ras_empty, ras_full     stack occupancy
//           ras_underflow           sticky: return attempted on an empty stack
// Option  : define ALIGN_CHECK_EN to add the sticky 'misalign' output; a branch
//           whose byte offset is not word aligned then leaves PC and stack untouched.
module pc_seq_ras
   import pc_pkg::*;
#(
   parameter int                   PC_W         = 32,
   parameter int                   IMM_W        = 12,
   parameter int                   ADDR_SHIFT   = 2,
   parameter int                   INC          = 1,
   parameter int                   STATE_W      = 4,
   parameter logic [STATE_W-1:0]   UPDATE_STATE = STATE_W'(UPDATE_STATE_DEFAULT),
   parameter int                   RAS_DEPTH    = 4,
   parameter logic [PC_W-1:0]      RESET_PC     = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STATE_W-1:0] estado,
   input  logic               stall,
   input  logic [1:0]         pc_src,
   input  logic [IMM_W-1:0]   imediato,
   input  logic [PC_W-1:0]    target,
   input  logic               call,
   output logic [PC_W-1:0]    PC,
   output logic [PC_W-1:0]    pc_plus_inc,
   output logic               ras_empty,
   output logic               ras_full,
   output logic               ras_underflow
`ifdef ALIGN_CHECK_EN
   ,
   output logic               misalign
`endif
);

   logic                    upd;
   logic [PC_W-1:0]         pc_next;
   logic [PC_W-1:0]         br_off;
   logic signed [OFF_W-1:0] imm_sext;
   logic [PC_W-1:0]         ras_top;
   logic                    push_req;
   logic                    pop_req;
   logic                    set_underflow;
`ifdef ALIGN_CHECK_EN
   logic                    imm_low_nz;
   logic                    set_misalign;
`endif

   // Reset already holds every register, so the strobe needs only state and stall.
   assign upd         = (estado == UPDATE_STATE) && !stall;
   assign pc_plus_inc = PC + PC_W'(INC);

   // Sign-extend the byte offset, convert to words, truncate to PC width
   // (all PC arithmetic wraps modulo 2^PC_W).
   assign imm_sext = {{(OFF_W-IMM_W){imediato[IMM_W-1]}}, imediato};
   assign br_off   = PC_W'(byte_to_word(imm_sext, ADDR_SHIFT));

`ifdef ALIGN_CHECK_EN
   assign imm_low_nz = (imediato & IMM_W'((1 << ADDR_SHIFT) - 1)) != '0;
`endif

   // Next-PC mux and stack requests, qualified by upd further down.
   always_comb begin
      pc_next       = pc_plus_inc;
      push_req      = 1'b0;
      pop_req       = 1'b0;
      set_underflow = 1'b0;
`ifdef ALIGN_CHECK_EN
      set_misalign  = 1'b0;
`endif
      case (pc_src_e'(pc_src))
         PC_SEQ: begin
            pc_next = pc_plus_inc;
         end
         PC_BR: begin
`ifdef ALIGN_CHECK_EN
            if (imm_low_nz) begin
               pc_next      = PC;
               set_misalign = 1'b1;
            end else begin
               pc_next  = PC + br_off;
               push_req = call;
            end
`else
            pc_next  = PC + br_off;
            push_req = call;
`endif
         end
         PC_JMP: begin
            pc_next  = target;
            push_req = call;
         end
         PC_RET: begin
            push_req = call;
            if (!ras_empty) begin
               pc_next = ras_top;
               pop_req = 1'b1;
            end else begin
               // Empty stack: fall through sequentially and record the fault.
               pc_next       = pc_plus_inc;
               set_underflow = 1'b1;
            end
         end
         default: begin
            pc_next = pc_plus_inc;
         end
      endcase
   end

   // The pushed value is always the pre-update PC+INC, including when it
   // replaces the top during a return.
   ras_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (upd && push_req),
      .pop       (upd && pop_req),
      .push_data (pc_plus_inc),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PC            <= RESET_PC;
         ras_underflow <= 1'b0;
      end else if (upd) begin
         PC <= pc_next;
         if (set_underflow) begin
            ras_underflow <= 1'b1;
         end
      end
   end

`ifdef ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign <= 1'b0;
      end else if (upd && set_misalign) begin
         misalign <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_seq_ras.sv
// Purpose : directed, table-driven bench for pc_seq_ras plus hand sequences
//           for asynchronous reset and (with ALIGN_CHECK_EN) the alignment trap.
// Latency : each table row is one clock; outputs sampled 1 time unit after the edge.
// Backpressure: exercised through stall and non-update states in the table.
module tb_pc_seq_ras;

   localparam logic [3:0] U = 4'b1000;
   localparam logic [3:0] I = 4'b0000;

`ifdef ALIGN_CHECK_EN
   localparam logic [31:0] BR_M2_PC = 32'd6;   // misaligned branch holds PC
`else
   localparam logic [31:0] BR_M2_PC = 32'd5;   // -2 bytes floors to -1 word
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  estado = '0;
   logic        stall = 1'b0;
   logic [1:0]  pc_src = '0;
   logic [11:0] imediato = '0;
   logic [31:0] target = '0;
   logic        call = 1'b0;
   logic [31:0] PC;
   logic [31:0] pc_plus_inc;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_underflow;
`ifdef ALIGN_CHECK_EN
   logic        misalign;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pc_seq_ras dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .estado        (estado),
      .stall         (stall),
      .pc_src        (pc_src),
      .imediato      (imediato),
      .target        (target),
      .call          (call),
      .PC            (PC),
      .pc_plus_inc   (pc_plus_inc),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_underflow (ras_underflow)
`ifdef ALIGN_CHECK_EN
      ,
      .misalign      (misalign)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  estado;
      logic        stall;
      logic [1:0]  src;
      logic [11:0] imm;
      logic [31:0] tgt;
      logic        call;
      logic [31:0] pc;
      logic        e;
      logic        f;
      logic        uf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic [3:0] st, input logic stl, input logic [1:0] src,
                              input logic [11:0] imm, input logic [31:0] tgt, input logic cl,
                              input logic [31:0] pc, input logic e, input logic f, input logic uf);
      vec_t r;
      r.estado = st; r.stall = stl; r.src = src; r.imm = imm; r.tgt = tgt; r.call = cl;
      r.pc = pc; r.e = e; r.f = f; r.uf = uf;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      estado   = t.estado;
      stall    = t.stall;
      pc_src   = t.src;
      imediato = t.imm;
      target   = t.tgt;
      call     = t.call;
   endtask

   task automatic check_state(input string tag, input logic [31:0] pc, input logic e,
                              input logic f, input logic uf);
      chk({tag, " PC"}, PC, pc);
      chk({tag, " pc_plus_inc"}, pc_plus_inc, pc + 32'd1);
      chk({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, e});
      chk({tag, " ras_full"}, {31'd0, ras_full}, {31'd0, f});
      chk({tag, " ras_underflow"}, {31'd0, ras_underflow}, {31'd0, uf});
   endtask

   task automatic step(input vec_t t, input string tag);
      drive(t);
      @(posedge clk);
      #1;
      check_state(tag, t.pc, t.e, t.f, t.uf);
   endtask

   initial begin
      // Sequential updates separated by idle cycles, then stall.
      vecs.push_back(v(U, 0, 2'b00, 12'h000, 32'd0,   0, 32'd1,  1, 0, 0));
      vecs.push_back(v(I, 0, 2'b00, 12'h000, 32'd0,   0, 32'd1,  1, 0, 0));
      vecs.push_back(v(U, 0, 2'b00, 12'h000, 32'd0,   0, 32'd2,  1, 0, 0));
      vecs.push_back(v(I, 0, 2'b00, 12'h000, 32'd0,   0, 32'd2,  1, 0, 0));
      vecs.push_back(v(U, 0, 2'b00, 12'h000, 32'd0,   0, 32'd3,  1, 0, 0));
      vecs.push_back(v(U, 1, 2'b00, 12'h000, 32'd0,   0, 32'd3,  1, 0, 0));
      // Relative branches, including wrap below zero and back.
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd10,  0, 32'd10, 1, 0, 0));
      vecs.push_back(v(U, 0, 2'b01, 12'h010, 32'd0,   0, 32'd14, 1, 0, 0));
      vecs.push_back(v(U, 0, 2'b01, 12'hFF0, 32'd0,   0, 32'd10, 1, 0, 0));
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd0,   0, 32'd0,  1, 0, 0));
      vecs.push_back(v(U, 0, 2'b01, 12'hFFC, 32'd0,   0, 32'hFFFF_FFFF, 1, 0, 0));
      vecs.push_back(v(U, 0, 2'b00, 12'h000, 32'd0,   0, 32'd0,  1, 0, 0));
      // Call / return pair.
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd5,   0, 32'd5,  1, 0, 0));
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd100, 1, 32'd100, 0, 0, 0));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   0, 32'd6,  1, 0, 0));
      // -2 byte branch (floors to -1 word unless alignment checking holds PC).
      vecs.push_back(v(U, 0, 2'b01, 12'hFFE, 32'd0,   0, BR_M2_PC, 1, 0, 0));
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd0,   0, 32'd0,  1, 0, 0));
      // Five nested calls at 0,10,20,30,40 overflow a 4-deep stack.
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd10,  1, 32'd10, 0, 0, 0));
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd20,  1, 32'd20, 0, 0, 0));
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd30,  1, 32'd30, 0, 0, 0));
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd40,  1, 32'd40, 0, 1, 0));
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd50,  1, 32'd50, 0, 1, 0));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   0, 32'd41, 0, 0, 0));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   0, 32'd31, 0, 0, 0));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   0, 32'd21, 0, 0, 0));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   0, 32'd11, 1, 0, 0));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   0, 32'd12, 1, 0, 1));
      // Return+call on empty: falls through, pushes, underflow stays set.
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   1, 32'd13, 0, 0, 1));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   0, 32'd13, 1, 0, 1));
      // Return+call on non-empty: top 50 replaced by 8.
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd49,  0, 32'd49, 1, 0, 1));
      vecs.push_back(v(U, 0, 2'b10, 12'h000, 32'd7,   1, 32'd7,  0, 0, 1));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   1, 32'd50, 0, 0, 1));
      vecs.push_back(v(U, 0, 2'b11, 12'h000, 32'd0,   0, 32'd8,  1, 0, 1));
      // Stalled call does nothing; call with sequential select is ignored.
      vecs.push_back(v(U, 1, 2'b10, 12'h000, 32'd99,  1, 32'd8,  1, 0, 1));
      vecs.push_back(v(U, 0, 2'b00, 12'h000, 32'd0,   1, 32'd9,  1, 0, 1));

      // Reset state.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", 32'd0, 1'b1, 1'b0, 1'b0);
`ifdef ALIGN_CHECK_EN
      chk("reset misalign", {31'd0, misalign}, 32'd0);
`endif
      #2 rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i], $sformatf("v%0d", i));
      end

      // Leave an entry on the stack so reset has something to clear.
      step(v(U, 0, 2'b10, 12'h000, 32'd20, 1, 32'd20, 0, 0, 1), "pre-rst call");

      // Reset asserted between edges acts immediately, and holds through an
      // edge even with an update requested.
      drive(v(U, 0, 2'b00, 12'h000, 32'd0, 0, 32'd0, 0, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      check_state("async rst", 32'd0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("rst hold PC", PC, 32'd0);
      rst_n = 1'b1;
      step(v(U, 0, 2'b00, 12'h000, 32'd0, 0, 32'd1, 1, 0, 0), "post-rst seq");

`ifdef ALIGN_CHECK_EN
      step(v(U, 0, 2'b00, 12'h000, 32'd0, 0, 32'd2, 1, 0, 0), "al seq2");
      step(v(U, 0, 2'b00, 12'h000, 32'd0, 0, 32'd3, 1, 0, 0), "al seq3");
      chk("al misalign pre", {31'd0, misalign}, 32'd0);
      step(v(U, 0, 2'b01, 12'h006, 32'd0, 1, 32'd3, 1, 0, 0), "al br006");
      chk("al misalign set", {31'd0, misalign}, 32'd1);
      step(v(U, 0, 2'b00, 12'h000, 32'd0, 0, 32'd4, 1, 0, 0), "al after");
      chk("al misalign sticky", {31'd0, misalign}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("al rst misalign", {31'd0, misalign}, 32'd0);
      chk("al rst PC", PC, 32'd0);
      rst_n = 1'b1;
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
